irq_event_ctrl: RTL and testbench

IRQ_EVENT_CTRL -- requirements
Module: irq_event_ctrl

---
 rtl/irq_event_ctrl.sv | 133 +++++++++++++
 tb/tb_irq_event_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_event_ctrl
// Description : Per-channel event capture with pending/enable/overrun
//               registers, saturating event counters, a small register
//               file and a registered level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_event_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ev_pulse,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [2:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_rvalid,
    output logic              irq
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_OVERRUN = 3'd2;
    localparam logic [2:0] ADDR_COUNT0  = 3'd4;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] overrun;
    logic [CNT_W-1:0]  count [NUM_CH];

    logic              wr_pending;
    logic              wr_enable;
    logic              wr_overrun;
    logic [NUM_CH-1:0] wmask;
    logic [NUM_CH-1:0] pend_clr;
    logic [NUM_CH-1:0] ovr_clr;
    logic [NUM_CH-1:0] new_ovr;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] overrun_next;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    // Only the low NUM_CH data bits carry meaning for any register.
    assign unused_wdata = &{1'b0, reg_wdata[31:NUM_CH]};

    assign wr_pending = reg_wr && (reg_addr == ADDR_PENDING);
    assign wr_enable  = reg_wr && (reg_addr == ADDR_ENABLE);
    assign wr_overrun = reg_wr && (reg_addr == ADDR_OVERRUN);
    assign wmask      = reg_wdata[NUM_CH-1:0];
    assign pend_clr   = wr_pending ? wmask : '0;
    assign ovr_clr    = wr_overrun ? wmask : '0;

    // An event arriving in the same cycle as its own W1C only re-arms the
    // pending bit; it is not treated as an overrun of the cleared event.
    assign new_ovr      = ev_pulse & pending & ~pend_clr;
    assign pending_next = (pending & ~pend_clr) | ev_pulse;
    assign overrun_next = (overrun & ~ovr_clr) | new_ovr;

    // Status/control registers and the registered interrupt level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            enable  <= '0;
            overrun <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= pending_next;
            overrun <= overrun_next;
            if (wr_enable) begin
                enable <= wmask;
            end
            irq <= |(pending & enable);
        end
    end

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt
            localparam logic [2:0] CH_ADDR = 3'(4 + ch);
            logic cnt_wr;
            assign cnt_wr = reg_wr && (reg_addr == CH_ADDR);

            // Saturating event counter; an event beats a same-cycle clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count[ch] <= '0;
                end else if (ev_pulse[ch]) begin
                    if (cnt_wr) begin
                        count[ch] <= CNT_ONE;
                    end else if (count[ch] != CNT_MAX) begin
                        count[ch] <= count[ch] + CNT_ONE;
                    end
                end else if (cnt_wr) begin
                    count[ch] <= '0;
                end
            end
        end
    endgenerate

    // Read mux over the pre-update register values, zero-extended.
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_PENDING: rd_mux[NUM_CH-1:0] = pending;
            ADDR_ENABLE:  rd_mux[NUM_CH-1:0] = enable;
            ADDR_OVERRUN: rd_mux[NUM_CH-1:0] = overrun;
            default:      rd_mux = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (reg_addr == (ADDR_COUNT0 + 3'(c))) begin
                rd_mux[CNT_W-1:0] = count[c];
            end
        end
    end

    // Read response one cycle after the strobe; data is zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            reg_rvalid <= reg_rd;
            reg_rdata  <= reg_rd ? rd_mux : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_event_ctrl
// Description : Directed self-checking bench for irq_event_ctrl with a read
//               scoreboard (expectations queued at the read strobe).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_event_ctrl;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] ev_pulse = '0;
    logic              reg_wr = 1'b0;
    logic              reg_rd = 1'b0;
    logic [2:0]        reg_addr = '0;
    logic [31:0]       reg_wdata = '0;
    logic [31:0]       reg_rdata;
    logic              reg_rvalid;
    logic              irq;

    int total = 0;
    int bad   = 0;
    logic mon_on = 1'b0;

    logic [31:0] sb_exp [$];
    string       sb_tag [$];
    logic [31:0] pop_exp;
    string       pop_tag;

    irq_event_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev_pulse   (ev_pulse),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        reg_rd   = 1'b1;
        reg_addr = addr;
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        tick();
        reg_rd = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick();
        reg_wr    = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        ev_pulse = mask;
        tick();
        ev_pulse = '0;
    endtask

    // Read-response monitor: pop one expectation per rvalid, else data must be 0.
    always @(negedge clk) begin
        if (mon_on) begin
            if (reg_rvalid) begin
                total++;
                assert (sb_exp.size() != 0) else begin
                    bad++;
                    $error("FAIL rd_unexpected: observed=rvalid expected=no_read data=%0h", reg_rdata);
                end
                if (sb_exp.size() != 0) begin
                    pop_exp = sb_exp.pop_front();
                    pop_tag = sb_tag.pop_front();
                    chk(pop_tag, reg_rdata, pop_exp);
                end
            end else begin
                chk("rdata_idle", reg_rdata, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rvalid", {31'b0, reg_rvalid}, 32'h0);
        rst_n = 1'b1;
        mon_on = 1'b1;
        rd(3'd0, 32'h0, "rst_pending");
        rd(3'd1, 32'h0, "rst_enable");
        rd(3'd2, 32'h0, "rst_overrun");
        rd(3'd4, 32'h0, "rst_count0");

        // Single event on an enabled channel: pending at T+1, irq at T+2
        wr(3'd1, 32'h1);
        pulse(4'h1);
        chk("irq_t1", {31'b0, irq}, 32'h0);
        tick();
        chk("irq_t2", {31'b0, irq}, 32'h1);
        rd(3'd0, 32'h1, "pend_ch0");
        rd(3'd4, 32'h1, "count0_one");
        rd(3'd1, 32'h1, "enable_rb");
        wr(3'd0, 32'h1);

        // Overrun on channel 2, then W1C drops irq one cycle later
        wr(3'd1, 32'h4);
        pulse(4'h4);
        pulse(4'h4);
        rd(3'd2, 32'h4, "ovr_ch2");
        rd(3'd6, 32'h2, "count2_two");
        chk("irq_ch2", {31'b0, irq}, 32'h1);
        wr(3'd0, 32'h4);
        chk("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        chk("irq_drop", {31'b0, irq}, 32'h0);
        rd(3'd0, 32'h0, "pend_cleared");
        wr(3'd2, 32'h4);
        rd(3'd2, 32'h0, "ovr_cleared");

        // W1C of PENDING coinciding with an event: set wins, no overrun
        pulse(4'h1);
        reg_wr = 1'b1; reg_addr = 3'd0; reg_wdata = 32'h1; ev_pulse = 4'h1;
        tick();
        reg_wr = 1'b0; reg_wdata = '0; ev_pulse = '0;
        rd(3'd0, 32'h1, "pend_set_wins");
        rd(3'd2, 32'h0, "ovr_not_set");
        rd(3'd4, 32'h3, "count0_three");

        // W1C of OVERRUN coinciding with a new overrun: set wins
        reg_wr = 1'b1; reg_addr = 3'd2; reg_wdata = 32'h1; ev_pulse = 4'h1;
        tick();
        reg_wr = 1'b0; reg_wdata = '0; ev_pulse = '0;
        rd(3'd2, 32'h1, "ovr_set_wins");

        // COUNT clear coinciding with an event: increment wins
        reg_wr = 1'b1; reg_addr = 3'd4; reg_wdata = 32'h0; ev_pulse = 4'h1;
        tick();
        reg_wr = 1'b0; ev_pulse = '0;
        rd(3'd4, 32'h1, "count0_clr_inc");

        // Saturation with CNT_W=4: 20 back-to-back events on channel 1
        ev_pulse = 4'h2;
        for (int i = 0; i < 20; i++) tick();
        ev_pulse = '0;
        rd(3'd5, 32'hF, "count1_sat");
        wr(3'd5, 32'h1234);
        rd(3'd5, 32'h0, "count1_clr");

        // Read in the same cycle as an event returns the pre-event value
        wr(3'd0, 32'hF);
        reg_rd = 1'b1; reg_addr = 3'd0; ev_pulse = 4'h8;
        sb_exp.push_back(32'h0); sb_tag.push_back("rd_pre_event");
        tick();
        reg_rd = 1'b0; ev_pulse = '0;
        rd(3'd0, 32'h8, "rd_post_event");
        rd(3'd7, 32'h1, "count3_one");

        // Reserved address and simultaneous read+write
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, 32'h0, "reserved");
        reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 3'd1; reg_wdata = 32'hA;
        sb_exp.push_back(32'h4); sb_tag.push_back("rdwr_old");
        tick();
        reg_rd = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
        rd(3'd1, 32'hA, "rdwr_new");

        // Asynchronous reset mid-operation with all channels pending
        wr(3'd1, 32'hF);
        pulse(4'hF);
        tick();
        chk("irq_before_rst", {31'b0, irq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_irq", {31'b0, irq}, 32'h0);
        chk("async_rvalid", {31'b0, reg_rvalid}, 32'h0);
        chk("async_rdata", reg_rdata, 32'h0);
        ev_pulse = 4'hF; reg_wr = 1'b1; reg_addr = 3'd1; reg_wdata = 32'hF; reg_rd = 1'b1;
        tick(); tick(); tick();
        chk("rst_held_irq", {31'b0, irq}, 32'h0);
        ev_pulse = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0;
        rst_n = 1'b1;
        tick();
        rd(3'd0, 32'h0, "post_rst_pending");
        rd(3'd1, 32'h0, "post_rst_enable");
        rd(3'd2, 32'h0, "post_rst_overrun");
        rd(3'd4, 32'h0, "post_rst_count0");
        rd(3'd7, 32'h0, "post_rst_count3");
        tick(); tick();
        chk("post_rst_irq", {31'b0, irq}, 32'h0);
        chk("sb_drained", sb_exp.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
